// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: shared access-size and controller-state encodings for the MEM-stage data memory.
package data_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic misaligned(input size_e sz, input logic [1:0] off);
        return (sz == SZ_RSVD) || (sz == SZ_HALF && off[0]) || (sz == SZ_WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/data_mem_ctrl_load_align.sv
// data_mem_ctrl_load_align: picks the big-endian byte/half of a word and sign/zero-extends it.
module data_mem_ctrl_load_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  size_e       i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Lower byte address means more significant lane.
    assign w_half = i_off[1] ? i_word[15:0] : i_word[31:16];
    assign w_byte = i_off[0] ? w_half[7:0] : w_half[15:8];

    always_comb begin
        o_data = (i_size == SZ_BYTE) ? {{24{i_signed & w_byte[7]}}, w_byte} :
                 (i_size == SZ_HALF) ? {{16{i_signed & w_half[15]}}, w_half} : i_word;
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed big-endian data memory with init sweep, registered loads and fault pulses.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter int          ADDR_LEN    = 32,
    parameter logic [31:0] INIT_W0     = 32'd1,
    parameter logic [31:0] INIT_W1     = 32'd1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clear_req,
    input  logic                i_req_valid,
    input  logic                i_req_write,
    input  logic [1:0]          i_req_size,
    input  logic                i_req_signed,
    input  logic [ADDR_LEN-1:0] i_address,
    input  logic [31:0]         i_data_in,
    output logic                o_ready,
    output logic                o_rd_valid,
    output logic [31:0]         o_data_out,
    output logic                o_err
);

    localparam int IW = $clog2(DEPTH_WORDS);

    logic [31:0] r_mem [DEPTH_WORDS];
    state_e      r_state, w_next;
    logic [IW-1:0] r_ptr;
    logic        w_init_we, w_acc, w_fault, w_load_req;
    logic [IW-1:0] w_idx;
    size_e       w_size;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_init_val, w_load;

    assign w_size     = size_e'(i_req_size);
    assign w_idx      = i_address[IW+1:2];
    assign w_acc      = i_req_valid & o_ready;
    assign w_load_req = w_acc & ~i_req_write;
    assign w_fault    = misaligned(w_size, i_address[1:0]) || (|i_address[ADDR_LEN-1:IW+2]);
    assign w_init_val = (r_ptr == '0) ? INIT_W0 : (r_ptr == IW'(1)) ? INIT_W1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_INIT;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == ST_INIT) w_next = (&r_ptr) ? ST_RUN : ST_INIT;
        else if (i_clear_req)   w_next = ST_INIT;
    end

    always_comb begin
        o_ready   = (r_state == ST_RUN);
        w_init_we = (r_state == ST_INIT);
    end

    // Bit 3 of the lane enable is byte offset 0, i.e. word bits [31:24].
    always_comb begin
        w_be    = '0;
        w_wdata = (w_size == SZ_BYTE) ? {4{i_data_in[7:0]}} :
                  (w_size == SZ_HALF) ? {2{i_data_in[15:0]}} : i_data_in;
        if (w_acc && i_req_write && !w_fault)
            w_be = (w_size == SZ_BYTE) ? (4'b1000 >> i_address[1:0]) :
                   (w_size == SZ_HALF) ? (i_address[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    end

    always_ff @(posedge clk) begin
        if (w_init_we) r_mem[r_ptr] <= w_init_val;
        else
            for (int b = 0; b < 4; b++)
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
    end

    data_mem_ctrl_load_align u_align (
        .i_word   (r_mem[w_idx]),
        .i_off    (i_address[1:0]),
        .i_size   (w_size),
        .i_signed (i_req_signed),
        .o_data   (w_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            o_rd_valid <= 1'b0;
            o_data_out <= '0;
            o_err      <= 1'b0;
        end else begin
            r_ptr      <= w_init_we ? r_ptr + 1'b1 : '0;
            o_rd_valid <= w_load_req;
            o_err      <= w_acc & w_fault;
            if (w_load_req) o_data_out <= w_fault ? '0 : w_load;
        end
    end

endmodule
